// File: rtl/id_ex_operand_stage_pkg.sv
// rtl/id_ex_operand_stage_pkg.sv - shared datapath constants and ID/EX stage record
//
// Purpose: widths, ALU op codes, the "no register" index and the registered
// ID/EX stage record shared by the operand stage and its forwarding mux.
package id_ex_operand_stage_pkg;

  localparam int DATA_W = 16;
  localparam int CTRL_W = 5;
  localparam int REG_W  = 4;

  localparam logic [REG_W-1:0] REG_NONE = '1;

  typedef enum logic [CTRL_W-1:0] {
    ALU_PASS_A = 5'd0,
    ALU_ADD    = 5'd1,
    ALU_SUB    = 5'd2,
    ALU_AND    = 5'd3,
    ALU_OR     = 5'd4
  } alu_op_e;

  localparam logic [CTRL_W-1:0] NOP_CTRL = ALU_PASS_A;

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [REG_W-1:0]  a_reg;
    logic [DATA_W-1:0] a_val;
    logic [REG_W-1:0]  b_reg;
    logic [DATA_W-1:0] b_val;
    logic [DATA_W-1:0] imm;
    logic              use_imm;
    logic [REG_W-1:0]  dst_reg;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } ex_stage_t;

  // Bubble and reset share one encoding: no side effects, no register
  // references (so nothing forwards into it and nothing hazards on it).
  localparam ex_stage_t STAGE_BUBBLE = '{
    valid:     1'b0,
    ctrl:      NOP_CTRL,
    a_reg:     REG_NONE,
    a_val:     '0,
    b_reg:     REG_NONE,
    b_val:     '0,
    imm:       '0,
    use_imm:   1'b0,
    dst_reg:   REG_NONE,
    reg_write: 1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0
  };

endpackage

// File: rtl/id_ex_operand_stage_operand_forward_mux.sv
// rtl/id_ex_operand_stage_operand_forward_mux.sv - EX operand forwarding select
//
// Purpose: pick the freshest value of one EX source register.
// Ports:
//   src_reg_i/src_val_i        registered source index and register-file value
//   mem_dst_reg_i/mem_reg_write_i/mem_result_i   EX/MEM write-back candidate
//   wb_dst_reg_i/wb_reg_write_i/wb_data_i        MEM/WB write-back candidate
//   fwd_val_o                  forwarded operand
module operand_forward_mux
  import id_ex_operand_stage_pkg::*;
(
  input  logic [REG_W-1:0]  src_reg_i,
  input  logic [DATA_W-1:0] src_val_i,
  input  logic [REG_W-1:0]  mem_dst_reg_i,
  input  logic              mem_reg_write_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic [REG_W-1:0]  wb_dst_reg_i,
  input  logic              wb_reg_write_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [DATA_W-1:0] fwd_val_o
);

  // EX/MEM is younger than MEM/WB, so it wins when both target the register.
  always_comb begin
    fwd_val_o = src_val_i;
    if (src_reg_i != REG_NONE) begin
      if (mem_reg_write_i && (mem_dst_reg_i == src_reg_i)) begin
        fwd_val_o = mem_result_i;
      end else if (wb_reg_write_i && (wb_dst_reg_i == src_reg_i)) begin
        fwd_val_o = wb_data_i;
      end
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX pipeline register with operand forwarding
//
// Purpose: registers the decoded instruction from ID, drives the ALU with
// forwarded operands in EX, and inserts bubbles on load-use hazards or flush.
// Ports:
//   clk_i, rst_i (sync, active high), stall_i (hold), flush_i (bubble)
//   id_*_i           decoded instruction from ID
//   mem_*_i, wb_*_i  forwarding sources from EX/MEM and MEM/WB
//   alu_ctrl_o/alu_a_o/alu_b_o   ALU inputs
//   ex_store_data_o  forwarded register B for stores
//   ex_dst_reg_o/ex_reg_write_o/ex_mem_read_o/ex_mem_write_o/ex_valid_o
//   load_use_stall_o combinational: ID must hold this cycle
module id_ex_operand_stage
  import id_ex_operand_stage_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic [REG_W-1:0]  id_src_a_reg_i,
  input  logic [DATA_W-1:0] id_src_a_val_i,
  input  logic [REG_W-1:0]  id_src_b_reg_i,
  input  logic [DATA_W-1:0] id_src_b_val_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic              id_use_imm_i,
  input  logic [REG_W-1:0]  id_dst_reg_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic [REG_W-1:0]  mem_dst_reg_i,
  input  logic              mem_reg_write_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic [REG_W-1:0]  wb_dst_reg_i,
  input  logic              wb_reg_write_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [DATA_W-1:0] ex_store_data_o,
  output logic [REG_W-1:0]  ex_dst_reg_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_valid_o,
  output logic              load_use_stall_o
);

  ex_stage_t stage_q;
  ex_stage_t stage_d;
  ex_stage_t id_stage;
  logic [DATA_W-1:0] fwd_b;

  assign id_stage = '{
    valid:     1'b1,
    ctrl:      id_ctrl_i,
    a_reg:     id_src_a_reg_i,
    a_val:     id_src_a_val_i,
    b_reg:     id_src_b_reg_i,
    b_val:     id_src_b_val_i,
    imm:       id_imm_i,
    use_imm:   id_use_imm_i,
    dst_reg:   id_dst_reg_i,
    reg_write: id_reg_write_i,
    mem_read:  id_mem_read_i,
    mem_write: id_mem_write_i
  };

  // A load's data is not available until MEM, so a dependent instruction in
  // ID cannot be fed by forwarding next cycle. A flushed ID slot is discarded
  // anyway, so it never needs to wait.
  assign load_use_stall_o = !flush_i && stage_q.valid && stage_q.mem_read &&
                            (stage_q.dst_reg != REG_NONE) &&
                            ((stage_q.dst_reg == id_src_a_reg_i) ||
                             (stage_q.dst_reg == id_src_b_reg_i));

  always_comb begin
    stage_d = id_stage;
    if (stall_i) begin
      stage_d = stage_q;
    end else if (flush_i || load_use_stall_o) begin
      stage_d = STAGE_BUBBLE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage_q <= STAGE_BUBBLE;
    end else begin
      stage_q <= stage_d;
    end
  end

  operand_forward_mux u_fwd_a (
    .src_reg_i       (stage_q.a_reg),
    .src_val_i       (stage_q.a_val),
    .mem_dst_reg_i   (mem_dst_reg_i),
    .mem_reg_write_i (mem_reg_write_i),
    .mem_result_i    (mem_result_i),
    .wb_dst_reg_i    (wb_dst_reg_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .wb_data_i       (wb_data_i),
    .fwd_val_o       (alu_a_o)
  );

  operand_forward_mux u_fwd_b (
    .src_reg_i       (stage_q.b_reg),
    .src_val_i       (stage_q.b_val),
    .mem_dst_reg_i   (mem_dst_reg_i),
    .mem_reg_write_i (mem_reg_write_i),
    .mem_result_i    (mem_result_i),
    .wb_dst_reg_i    (wb_dst_reg_i),
    .wb_reg_write_i  (wb_reg_write_i),
    .wb_data_i       (wb_data_i),
    .fwd_val_o       (fwd_b)
  );

  // Stores need register B even when the ALU uses the immediate for the address.
  assign alu_b_o         = stage_q.use_imm ? stage_q.imm : fwd_b;
  assign ex_store_data_o = fwd_b;

  assign alu_ctrl_o     = stage_q.ctrl;
  assign ex_dst_reg_o   = stage_q.dst_reg;
  assign ex_reg_write_o = stage_q.reg_write;
  assign ex_mem_read_o  = stage_q.mem_read;
  assign ex_mem_write_o = stage_q.mem_write;
  assign ex_valid_o     = stage_q.valid;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - self-checking bench for id_ex_operand_stage
module tb_id_ex_operand_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic [4:0]  id_ctrl;
  logic [3:0]  id_a_r, id_b_r, id_dst, mem_dst, wb_dst;
  logic [15:0] id_a_v, id_b_v, id_imm, mem_res, wb_data;
  logic        id_use_imm, id_rw, id_mr, id_mw, mem_rw, wb_rw;
  logic [4:0]  alu_ctrl;
  logic [15:0] alu_a, alu_b, store_data;
  logic [3:0]  ex_dst;
  logic        ex_rw, ex_mr, ex_mw, ex_valid, lus;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage dut (
    .clk_i(clk), .rst_i(rst), .stall_i(stall), .flush_i(flush),
    .id_ctrl_i(id_ctrl), .id_src_a_reg_i(id_a_r), .id_src_a_val_i(id_a_v),
    .id_src_b_reg_i(id_b_r), .id_src_b_val_i(id_b_v), .id_imm_i(id_imm),
    .id_use_imm_i(id_use_imm), .id_dst_reg_i(id_dst), .id_reg_write_i(id_rw),
    .id_mem_read_i(id_mr), .id_mem_write_i(id_mw),
    .mem_dst_reg_i(mem_dst), .mem_reg_write_i(mem_rw), .mem_result_i(mem_res),
    .wb_dst_reg_i(wb_dst), .wb_reg_write_i(wb_rw), .wb_data_i(wb_data),
    .alu_ctrl_o(alu_ctrl), .alu_a_o(alu_a), .alu_b_o(alu_b),
    .ex_store_data_o(store_data), .ex_dst_reg_o(ex_dst),
    .ex_reg_write_o(ex_rw), .ex_mem_read_o(ex_mr), .ex_mem_write_o(ex_mw),
    .ex_valid_o(ex_valid), .load_use_stall_o(lus)
  );

  // Reference model: the instruction currently sitting in EX, as a plain record.
  typedef struct {
    bit        valid;
    int        ctrl;
    int        a_r, a_v, b_r, b_v, imm;
    bit        use_imm;
    int        dst;
    bit        rw, mr, mw;
    bit        vals_known;   // operand values are defined (reset or real instruction)
  } instr_t;

  instr_t m;
  bit     m_init = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(int r, int v);
    if (r == 15) return v;
    if (mem_rw && int'(mem_dst) == r) return int'(mem_res);
    if (wb_rw && int'(wb_dst) == r) return int'(wb_data);
    return v;
  endfunction

  function automatic bit model_lus();
    if (flush || !m.valid || !m.mr || m.dst == 15) return 0;
    return (m.dst == int'(id_a_r)) || (m.dst == int'(id_b_r));
  endfunction

  function automatic instr_t empty_slot(bit known);
    instr_t e;
    e.valid = 0; e.ctrl = 0; e.a_r = 15; e.a_v = 0; e.b_r = 15; e.b_v = 0;
    e.imm = 0; e.use_imm = 0; e.dst = 15; e.rw = 0; e.mr = 0; e.mw = 0;
    e.vals_known = known;
    return e;
  endfunction

  task automatic check_all();
    if (!m_init) return;
    chk("load_use_stall", 32'(lus), 32'(model_lus()));
    chk("ex_valid", 32'(ex_valid), 32'(m.valid));
    chk("alu_ctrl", 32'(alu_ctrl), m.ctrl);
    chk("ex_dst_reg", 32'(ex_dst), m.dst);
    chk("ex_reg_write", 32'(ex_rw), 32'(m.rw));
    chk("ex_mem_read", 32'(ex_mr), 32'(m.mr));
    chk("ex_mem_write", 32'(ex_mw), 32'(m.mw));
    if (m.vals_known) begin
      chk("alu_a", 32'(alu_a), pick(m.a_r, m.a_v));
      chk("alu_b", 32'(alu_b), m.use_imm ? m.imm : pick(m.b_r, m.b_v));
      chk("ex_store_data", 32'(store_data), pick(m.b_r, m.b_v));
    end
  endtask

  // Check current outputs, advance the model by the edge rules, then clock.
  task automatic step();
    instr_t n;
    #2;
    check_all();
    if (rst) begin
      n = empty_slot(1); m_init = 1;
    end else if (stall) begin
      n = m;
    end else if (flush || model_lus()) begin
      n = empty_slot(0);
    end else begin
      n.valid = 1; n.ctrl = id_ctrl; n.a_r = id_a_r; n.a_v = id_a_v;
      n.b_r = id_b_r; n.b_v = id_b_v; n.imm = id_imm; n.use_imm = id_use_imm;
      n.dst = id_dst; n.rw = id_rw; n.mr = id_mr; n.mw = id_mw; n.vals_known = 1;
    end
    @(posedge clk);
    #1;
    m = n;
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0;
    id_ctrl = 0; id_a_r = 4'hF; id_a_v = 0; id_b_r = 4'hF; id_b_v = 0;
    id_imm = 0; id_use_imm = 0; id_dst = 4'hF; id_rw = 0; id_mr = 0; id_mw = 0;
    mem_dst = 4'hF; mem_rw = 0; mem_res = 0; wb_dst = 4'hF; wb_rw = 0; wb_data = 0;
  endtask

  function automatic logic [3:0] rnd_reg();
    int r = $urandom_range(0, 4);
    return (r == 4) ? 4'hF : 4'(r);
  endfunction

  task automatic rnd_inputs();
    id_ctrl = 5'($urandom); id_a_r = rnd_reg(); id_a_v = 16'($urandom);
    id_b_r = rnd_reg(); id_b_v = 16'($urandom); id_imm = 16'($urandom);
    id_use_imm = 1'($urandom); id_dst = rnd_reg(); id_rw = 1'($urandom);
    id_mr = ($urandom_range(0, 2) == 0); id_mw = 1'($urandom);
    mem_dst = rnd_reg(); mem_rw = 1'($urandom); mem_res = 16'($urandom);
    wb_dst = rnd_reg(); wb_rw = 1'($urandom); wb_data = 16'($urandom);
    stall = ($urandom_range(0, 5) == 0);
    flush = ($urandom_range(0, 7) == 0);
    rst = ($urandom_range(0, 99) == 0);
  endtask

  initial begin
    idle();
    #1;
    // Reset for two cycles with random inputs
    for (int i = 0; i < 2; i++) begin
      rnd_inputs(); rst = 1; stall = 1'($urandom); step();
    end
    idle(); #1;
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_ctrl", 32'(alu_ctrl), 0);
    chk("rst_alu_a", 32'(alu_a), 0);
    chk("rst_alu_b", 32'(alu_b), 0);
    chk("rst_dst", 32'(ex_dst), 32'hF);

    // Immediate ALU op
    idle(); id_ctrl = 2; id_a_r = 1; id_a_v = 16'h0005; id_imm = 16'h0003;
    id_use_imm = 1; id_dst = 4; id_rw = 1; step();
    idle(); #1;
    chk("imm_ctrl", 32'(alu_ctrl), 2);
    chk("imm_alu_a", 32'(alu_a), 5);
    chk("imm_alu_b", 32'(alu_b), 3);

    // Forwarding priority on operand A
    idle(); id_ctrl = 1; id_a_r = 2; id_a_v = 16'h1111; id_dst = 6; id_rw = 1; step();
    idle(); mem_dst = 2; mem_rw = 1; mem_res = 16'h2222;
    wb_dst = 2; wb_rw = 1; wb_data = 16'h3333; #1;
    chk("fwd_mem", 32'(alu_a), 32'h2222);
    mem_rw = 0; #1;
    chk("fwd_wb", 32'(alu_a), 32'h3333);
    wb_rw = 0; #1;
    chk("fwd_none", 32'(alu_a), 32'h1111);
    step();

    // Load-use hazard
    idle(); id_mr = 1; id_dst = 3; id_rw = 1; id_a_r = 0; step();
    idle(); id_ctrl = 6; id_b_r = 3; id_dst = 7; id_rw = 1; #1;
    chk("lus_set", 32'(lus), 1);
    step();
    chk("lus_bubble_valid", 32'(ex_valid), 0);
    chk("lus_bubble_ctrl", 32'(alu_ctrl), 0);
    step();
    chk("lus_loaded_valid", 32'(ex_valid), 1);
    chk("lus_loaded_ctrl", 32'(alu_ctrl), 6);

    // Stall overrides flush
    idle(); stall = 1; flush = 1; id_ctrl = 9;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_valid", 32'(ex_valid), 1);
      chk("stall_ctrl", 32'(alu_ctrl), 6);
      chk("stall_dst", 32'(ex_dst), 7);
    end
    stall = 0; step();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_dst", 32'(ex_dst), 32'hF);

    // Store with immediate address and WB-forwarded data
    idle(); id_ctrl = 1; id_mw = 1; id_use_imm = 1; id_imm = 16'h0004;
    id_b_r = 5; id_b_v = 16'h1234; step();
    idle(); wb_dst = 5; wb_rw = 1; wb_data = 16'hBEEF; #1;
    chk("store_alu_b", 32'(alu_b), 32'h0004);
    chk("store_data", 32'(store_data), 32'hBEEF);
    chk("store_mem_write", 32'(ex_mw), 1);
    step();

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      rnd_inputs();
      step();
    end
    #2;
    check_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
